// File: rtl/n8_pkg.sv
// Shared definitions for the NES-style serial controller link.
// The driver and the responder both import this package so the bit order lives in one place.
package n8_pkg;

    localparam int N8_FRAME_BITS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } resp_state_t;

endpackage

// File: rtl/n8_input_cond.sv
// Asynchronous input conditioner: flop synchronizer, consecutive-sample glitch filter,
// and one-cycle rise/fall strobes that are aligned with the filtered level change.
module n8_input_cond #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg;
    logic                   level_reg;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   synced;

    assign synced = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
        end
    end

    // The counter tracks how long the synced value has disagreed with the filtered level;
    // any sample that agrees again restarts it, so short excursions never get through.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            if (synced == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(FILTER_CYCLES - 1)) begin
                cnt_reg   <= '0;
                level_reg <= synced;
                rise_reg  <= synced;
                fall_reg  <= ~synced;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/n8_responder.sv
// Device end of the NES-style controller link: latches eight buttons and shifts them out
// active-low on data_out under control of the initiator's latch and pulse lines.
module n8_responder
    import n8_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int NUM_BUTTONS   = N8_FRAME_BITS
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       latch_in,
    input  logic       pulse_in,
    input  logic       a,
    input  logic       b,
    input  logic       select,
    input  logic       start,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic       data_out,
    output logic       frame_done,
    output logic [3:0] shift_cnt,
    output logic       overrun
);

    localparam logic [3:0] LAST_CNT = 4'(NUM_BUTTONS);

    logic [NUM_BUTTONS-1:0] buttons;
    logic [1:0]             raw_in;
    logic [1:0]             level_vec;
    logic [1:0]             rise_vec;
    logic [1:0]             fall_vec;
    logic                   latch_rise;
    logic                   latch_fall;
    logic                   pulse_rise;
    logic                   unused_cond;

    resp_state_t            state_reg, state_next;
    logic [NUM_BUTTONS-1:0] sr_reg, sr_next;
    logic [3:0]             cnt_reg, cnt_next;
    logic                   data_out_reg, data_out_next;
    logic                   frame_done_reg, frame_done_next;
    logic                   overrun_reg, overrun_next;

    assign buttons[BTN_A]      = a;
    assign buttons[BTN_B]      = b;
    assign buttons[BTN_SELECT] = select;
    assign buttons[BTN_START]  = start;
    assign buttons[BTN_UP]     = up;
    assign buttons[BTN_DOWN]   = down;
    assign buttons[BTN_LEFT]   = left;
    assign buttons[BTN_RIGHT]  = right;

    // Index 0 conditions latch_in, index 1 conditions pulse_in.
    assign raw_in = {pulse_in, latch_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cond
            n8_input_cond #(
                .SYNC_STAGES  (SYNC_STAGES),
                .FILTER_CYCLES(FILTER_CYCLES)
            ) u_cond (
                .CLOCK_50(CLOCK_50),
                .reset   (reset),
                .din     (raw_in[gi]),
                .level   (level_vec[gi]),
                .rise    (rise_vec[gi]),
                .fall    (fall_vec[gi])
            );
        end
    endgenerate

    assign latch_rise  = rise_vec[0];
    assign latch_fall  = fall_vec[0];
    assign pulse_rise  = rise_vec[1];
    assign unused_cond = ^{level_vec, fall_vec[1]};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg      <= IDLE;
            sr_reg         <= '0;
            cnt_reg        <= '0;
            data_out_reg   <= 1'b1;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sr_reg         <= sr_next;
            cnt_reg        <= cnt_next;
            data_out_reg   <= data_out_next;
            frame_done_reg <= frame_done_next;
            overrun_reg    <= overrun_next;
        end
    end

    // A latch rise pre-empts everything, including a pulse rise in the same cycle.
    always_comb begin
        state_next      = state_reg;
        sr_next         = sr_reg;
        cnt_next        = cnt_reg;
        overrun_next    = overrun_reg;
        frame_done_next = 1'b0;
        if (latch_rise) begin
            state_next   = LOAD;
            sr_next      = buttons;
            cnt_next     = '0;
            overrun_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                end
                LOAD: begin
                    sr_next      = buttons;
                    cnt_next     = '0;
                    overrun_next = 1'b0;
                    if (latch_fall) begin
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (pulse_rise && (cnt_reg < LAST_CNT)) begin
                        sr_next  = sr_reg >> 1;
                        cnt_next = cnt_reg + 4'd1;
                        if (cnt_next == LAST_CNT) begin
                            frame_done_next = 1'b1;
                            state_next      = DONE;
                        end
                    end
                end
                DONE: begin
                    cnt_next = LAST_CNT;
                    if (pulse_rise) begin
                        overrun_next = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
        data_out_next = ((state_next == LOAD) || (state_next == SHIFT)) ? ~sr_next[0] : 1'b1;
    end

    assign data_out   = data_out_reg;
    assign frame_done = frame_done_reg;
    assign shift_cnt  = cnt_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_n8_responder.sv
// Directed bench for n8_responder: table of button frames with hand-computed serial patterns,
// followed by hand-written sequences for filtering, overrun, abort, reset and loopback.
module tb_n8_responder;

    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int L    = SYNC + FILT;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       latch_in = 1'b0;
    logic       pulse_in = 1'b0;
    logic       a = 1'b0, b = 1'b0, select = 1'b0, start = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic       data_out;
    logic       frame_done;
    logic [3:0] shift_cnt;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fd_count = 0;
    int fd_cycle = 0;

    typedef struct {
        logic [7:0] btn;
        logic [7:0] exp_seq;
    } vec_t;

    vec_t vecs [5];

    n8_responder #(
        .SYNC_STAGES  (SYNC),
        .FILTER_CYCLES(FILT),
        .NUM_BUTTONS  (8)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .latch_in  (latch_in),
        .pulse_in  (pulse_in),
        .a         (a),
        .b         (b),
        .select    (select),
        .start     (start),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .data_out  (data_out),
        .frame_done(frame_done),
        .shift_cnt (shift_cnt),
        .overrun   (overrun)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (frame_done === 1'b1) begin
            fd_count = fd_count + 1;
            fd_cycle = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic set_buttons(input logic [7:0] v);
        {right, left, down, up, start, select, b, a} = v;
    endtask

    task automatic pulse(input int hi, input int lo);
        pulse_in = 1'b1;
        tick(hi);
        pulse_in = 1'b0;
        tick(lo);
    endtask

    task automatic run_frame(input int idx, input logic [7:0] btn, input logic [7:0] exp_seq,
                             input bit chk_timing);
        int         fd0;
        int         rise_cyc;
        logic [7:0] seen;
        fd0      = fd_count;
        rise_cyc = 0;
        seen     = '0;
        set_buttons(btn);
        latch_in = 1'b1;
        tick(20);
        latch_in = 1'b0;
        tick(20);
        for (int i = 0; i < 8; i++) begin
            seen[i] = data_out;
            check("frame_bit", {7'd0, data_out}, {7'd0, exp_seq[i]});
            if (i == 7) rise_cyc = cyc;
            pulse(20, 20);
        end
        check("frame_tail", {7'd0, data_out}, 8'd1);
        check("frame_cnt", {4'd0, shift_cnt}, 8'd8);
        check("frame_done_count", 8'(fd_count - fd0), 8'd1);
        if (chk_timing) check("frame_done_latency", 8'(fd_cycle - rise_cyc), 8'(L + 1));
        $display("frame %0d: buttons %02h serial %02h expected %02h", idx, btn, seen, exp_seq);
    endtask

    initial begin
        vecs[0] = '{btn: 8'h89, exp_seq: 8'h76};
        vecs[1] = '{btn: 8'h00, exp_seq: 8'hFF};
        vecs[2] = '{btn: 8'hFF, exp_seq: 8'h00};
        vecs[3] = '{btn: 8'h5A, exp_seq: 8'hA5};
        vecs[4] = '{btn: 8'h01, exp_seq: 8'hFE};

        // Reset with both async lines high.
        set_buttons(8'h01);
        latch_in = 1'b1;
        pulse_in = 1'b1;
        reset    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("rst_data_out", {7'd0, data_out}, 8'd1);
            check("rst_shift_cnt", {4'd0, shift_cnt}, 8'd0);
            check("rst_overrun", {7'd0, overrun}, 8'd0);
            check("rst_frame_done", {7'd0, frame_done}, 8'd0);
        end
        reset = 1'b0;
        tick(20);
        check("latch_high_after_reset", {7'd0, data_out}, 8'd0);
        check("load_cnt", {4'd0, shift_cnt}, 8'd0);
        latch_in = 1'b0;
        pulse_in = 1'b0;
        tick(20);
        check("shift_entry_cnt", {4'd0, shift_cnt}, 8'd0);
        $display("reset sequence done");

        for (int v = 0; v < 5; v++) begin
            run_frame(v, vecs[v].btn, vecs[v].exp_seq, v == 0);
        end

        // Ninth pulse after a complete frame.
        pulse(20, 20);
        check("overrun_set", {7'd0, overrun}, 8'd1);
        check("overrun_data_out", {7'd0, data_out}, 8'd1);
        check("overrun_cnt", {4'd0, shift_cnt}, 8'd8);
        latch_in = 1'b1;
        tick(20);
        check("overrun_cleared", {7'd0, overrun}, 8'd0);
        check("relatch_cnt", {4'd0, shift_cnt}, 8'd0);
        $display("overrun sequence done");

        // Transparent load while latch high, frozen after fall.
        set_buttons(8'h00);
        tick(3);
        check("load_track_a0", {7'd0, data_out}, 8'd1);
        a = 1'b1;
        tick(3);
        check("load_track_a1", {7'd0, data_out}, 8'd0);
        latch_in = 1'b0;
        tick(20);
        check("shift_hold_a", {7'd0, data_out}, 8'd0);
        a = 1'b0;
        tick(20);
        check("shift_ignore_a", {7'd0, data_out}, 8'd0);
        $display("transparent load sequence done");

        // Pulse excursion one cycle short of the filter length.
        pulse(FILT - 1, 20);
        check("short_pulse_cnt", {4'd0, shift_cnt}, 8'd0);
        check("short_pulse_data", {7'd0, data_out}, 8'd0);
        pulse(20, 20);
        check("real_pulse_cnt", {4'd0, shift_cnt}, 8'd1);
        check("real_pulse_data", {7'd0, data_out}, 8'd1);
        $display("glitch filter sequence done");

        // Abort after three pulses with latch and pulse rising together.
        a = 1'b1;
        pulse(20, 20);
        pulse(20, 20);
        check("abort_pre_cnt", {4'd0, shift_cnt}, 8'd3);
        begin
            int fd0;
            fd0      = fd_count;
            latch_in = 1'b1;
            pulse_in = 1'b1;
            tick(20);
            check("abort_cnt", {4'd0, shift_cnt}, 8'd0);
            check("abort_no_frame_done", 8'(fd_count - fd0), 8'd0);
            check("abort_load_data", {7'd0, data_out}, 8'd0);
        end
        pulse_in = 1'b0;
        tick(20);
        latch_in = 1'b0;
        pulse_in = 1'b1;
        tick(20);
        check("fall_with_pulse_cnt", {4'd0, shift_cnt}, 8'd0);
        check("fall_with_pulse_data", {7'd0, data_out}, 8'd0);
        pulse_in = 1'b0;
        tick(20);
        check("pulse_fall_cnt", {4'd0, shift_cnt}, 8'd0);
        $display("abort sequence done");

        // Reset mid-SHIFT with both lines high.
        pulse(20, 20);
        check("pre_reset_cnt", {4'd0, shift_cnt}, 8'd1);
        latch_in = 1'b1;
        pulse_in = 1'b1;
        reset    = 1'b1;
        tick(1);
        check("midrst_data_out", {7'd0, data_out}, 8'd1);
        check("midrst_cnt", {4'd0, shift_cnt}, 8'd0);
        check("midrst_overrun", {7'd0, overrun}, 8'd0);
        check("midrst_frame_done", {7'd0, frame_done}, 8'd0);
        reset    = 1'b0;
        latch_in = 1'b0;
        pulse_in = 1'b0;
        tick(20);
        check("idle_data_out", {7'd0, data_out}, 8'd1);
        latch_in = 1'b1;
        tick(2);
        latch_in = 1'b0;
        tick(20);
        check("latch_glitch_idle", {7'd0, data_out}, 8'd1);
        pulse(20, 20);
        check("idle_pulse_cnt", {4'd0, shift_cnt}, 8'd0);
        check("idle_pulse_data", {7'd0, data_out}, 8'd1);
        $display("mid-frame reset sequence done");

        // Loopback against an initiator model that samples before each pulse.
        for (int f = 0; f < 4; f++) begin
            logic [7:0] btn;
            logic [7:0] rx;
            btn = 8'($urandom_range(0, 255));
            rx  = '0;
            set_buttons(btn);
            latch_in = 1'b1;
            tick(20);
            latch_in = 1'b0;
            tick(20);
            for (int i = 0; i < 8; i++) begin
                rx[i] = ~data_out;
                pulse(20, 20);
            end
            check("loopback_byte", rx, btn);
            $display("loopback %0d: buttons %02h received %02h", f, btn, rx);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
